// File: rtl/param_fifo_if.sv
// -----------------------------------------------------------------------------
// param_fifo_if -- bundle of the FIFO access and status signals.
//
// Signals (names follow the existing FIFO pinout):
//   WR_EN, RD_EN, CLR_ERR, DIN      : requests driven by the FIFO user
//   DOUT                            : read data
//   FULL, EMPTY                     : occupancy extremes
//   ALMOST_FULL, ALMOST_EMPTY       : threshold flags
//   COUNT                           : current occupancy
//   OVERFLOW, UNDERFLOW             : sticky error flags
// Modports:
//   master : the FIFO user (drives requests, observes status)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface param_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  WR_EN;
    logic                  RD_EN;
    logic                  CLR_ERR;
    logic [DATA_WIDTH-1:0] DIN;
    logic [DATA_WIDTH-1:0] DOUT;
    logic                  FULL;
    logic                  EMPTY;
    logic                  ALMOST_FULL;
    logic                  ALMOST_EMPTY;
    logic [CW-1:0]         COUNT;
    logic                  OVERFLOW;
    logic                  UNDERFLOW;

    modport master (
        output WR_EN, RD_EN, CLR_ERR, DIN,
        input  DOUT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT,
               OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  WR_EN, RD_EN, CLR_ERR, DIN,
        output DOUT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT,
               OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/param_fifo.sv
// -----------------------------------------------------------------------------
// param_fifo -- parameterised synchronous FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// selectable read mode (registered read or first-word-fall-through).
//
// Ports:
//   CLK   : clock, all state changes on the rising edge
//   RST_N : asynchronous active-low reset (contents are discarded)
//   bus   : param_fifo_if slave modport carrying requests, data and status
//
// Parameters:
//   DATA_WIDTH : word width
//   FIFO_DEPTH : entry count, power of two >= 2
//   AF_THRESH  : ALMOST_FULL asserted when COUNT >= AF_THRESH
//   AE_THRESH  : ALMOST_EMPTY asserted when COUNT <= AE_THRESH
//   FWFT       : 0 = DOUT loads on an accepted read, 1 = head shown directly
// -----------------------------------------------------------------------------
module param_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic          CLK,
    input  logic          RST_N,
    param_fifo_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;

    logic full_s;
    logic empty_s;
    logic wr_ok_s;
    logic rd_ok_s;

    // Status decodes straight from the registered count so they track COUNT
    // in the same cycle it changes.
    assign full_s  = (count_q == CW'(FIFO_DEPTH));
    assign empty_s = (count_q == {CW{1'b0}});

    // Acceptance is judged on pre-edge state; each side is independent, so a
    // full FIFO still reads and an empty FIFO still writes.
    assign wr_ok_s = bus.WR_EN && !full_s;
    assign rd_ok_s = bus.RD_EN && !empty_s;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        // Power-of-two depth makes natural pointer wrap the modulo.
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A fresh error in the clearing cycle takes priority over the clear.
        if (bus.WR_EN && full_s) begin
            overflow_d = 1'b1;
        end else if (bus.CLR_ERR) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (bus.RD_EN && empty_s) begin
            underflow_d = 1'b1;
        end else if (bus.CLR_ERR) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; left unreset because reset empties the FIFO logically.
    always_ff @(posedge CLK) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= bus.DIN;
        end
    end

    generate
        if (FWFT == 0) begin : g_registered_read
            logic [DATA_WIDTH-1:0] dout_q, dout_d;

            // Output register loads the head only on an accepted read.
            always_comb begin
                if (rd_ok_s) begin
                    dout_d = mem_q[rd_ptr_q];
                end else begin
                    dout_d = dout_q;
                end
            end

            // Output data register with asynchronous reset.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    dout_q <= {DATA_WIDTH{1'b0}};
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign bus.DOUT = dout_q;
        end else begin : g_fwft_read
            logic [DATA_WIDTH-1:0] dout_s;

            // Head entry falls through; forced to zero while empty.
            always_comb begin
                if (empty_s) begin
                    dout_s = {DATA_WIDTH{1'b0}};
                end else begin
                    dout_s = mem_q[rd_ptr_q];
                end
            end

            assign bus.DOUT = dout_s;
        end
    endgenerate

    assign bus.FULL         = full_s;
    assign bus.EMPTY        = empty_s;
    assign bus.ALMOST_FULL  = (count_q >= CW'(AF_THRESH));
    assign bus.ALMOST_EMPTY = (count_q <= CW'(AE_THRESH));
    assign bus.COUNT        = count_q;
    assign bus.OVERFLOW     = overflow_q;
    assign bus.UNDERFLOW    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_fifo -- scoreboard bench for param_fifo.
// u_dut0 : defaults (depth 16, registered read); read data checked by a
//          monitor that pops the expected-word queue filled by the driver.
// u_dut1 : FWFT=1 instance exercised with directed checks.
// -----------------------------------------------------------------------------
module tb_param_fifo;
    logic CLK;
    logic RST_N;

    param_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) bus0 ();
    param_fifo_if #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) bus1 ();

    param_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(0)) u_dut0 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus0)
    );

    param_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1)) u_dut1 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    // Bench reference model of dut0
    logic [7:0] m_q[$];
    logic       m_ovf;
    logic       m_udf;

    // Scoreboard: expected read words, and whether a read was issued this cycle
    logic [7:0] exp_q[$];
    logic       rd_issue0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.WR_EN = 1'b0; bus0.RD_EN = 1'b0; bus0.CLR_ERR = 1'b0; bus0.DIN = 8'h00;
        bus1.WR_EN = 1'b0; bus1.RD_EN = 1'b0; bus1.CLR_ERR = 1'b0; bus1.DIN = 8'h00;
        rd_issue0 = 1'b0;
    endtask

    task automatic check_status0(input string tag);
        int n;
        n = m_q.size();
        chk({tag, "_count"}, 32'(bus0.COUNT), 32'(n));
        chk({tag, "_full"},  32'(bus0.FULL),  32'(n == 16));
        chk({tag, "_empty"}, 32'(bus0.EMPTY), 32'(n == 0));
        chk({tag, "_af"},    32'(bus0.ALMOST_FULL),  32'(n >= 14));
        chk({tag, "_ae"},    32'(bus0.ALMOST_EMPTY), 32'(n <= 2));
        chk({tag, "_ovf"},   32'(bus0.OVERFLOW),  32'(m_ovf));
        chk({tag, "_udf"},   32'(bus0.UNDERFLOW), 32'(m_udf));
    endtask

    // One cycle of dut0 traffic: update model, push expected read data, step, check.
    task automatic drv0(input logic we, input logic re, input logic clr, input logic [7:0] d,
                        input string tag);
        logic wok;
        logic rok;
        wok = we && (m_q.size() < 16);
        rok = re && (m_q.size() > 0);
        if (we && m_q.size() == 16)     m_ovf = 1'b1;
        else if (clr)                   m_ovf = 1'b0;
        if (re && m_q.size() == 0)      m_udf = 1'b1;
        else if (clr)                   m_udf = 1'b0;
        if (rok) exp_q.push_back(m_q.pop_front());
        if (wok) m_q.push_back(d);
        bus0.WR_EN = we; bus0.RD_EN = re; bus0.CLR_ERR = clr; bus0.DIN = d;
        rd_issue0 = rok;
        step();
        check_status0(tag);
        idle_inputs();
    endtask

    // Monitor: a read accepted at an edge presents its word on DOUT after that edge.
    initial begin
        logic p;
        logic [7:0] e;
        forever begin
            @(posedge CLK);
            p = rd_issue0;
            #2;
            if (p) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rd_data: DOUT=0x%0h with no expected word queued", bus0.DOUT);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(bus0.DOUT), 32'(e));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time 200000, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
        idle_inputs();
        RST_N = 1'b0;
        #12;
        // Reset state
        check_status0("rst");
        chk("rst_dout", 32'(bus0.DOUT), 32'h0);
        #11;
        RST_N = 1'b1;

        // 16 writes 0x01..0x10, ALMOST_FULL turns on at 14
        for (int i = 0; i < 16; i++) begin
            drv0(1'b1, 1'b0, 1'b0, 8'(i + 1), "wr");
            if (i == 12) chk("af_at13", 32'(bus0.ALMOST_FULL), 32'h0);
            if (i == 13) chk("af_at14", 32'(bus0.ALMOST_FULL), 32'h1);
        end
        chk("full_count", 32'(bus0.COUNT), 32'd16);
        chk("full_flag",  32'(bus0.FULL),  32'h1);

        // 17th write overflows
        drv0(1'b1, 1'b0, 1'b0, 8'h99, "ovf");
        chk("ovf_set",   32'(bus0.OVERFLOW), 32'h1);
        chk("ovf_count", 32'(bus0.COUNT),    32'd16);
        // Clear with simultaneous overflow: error wins
        drv0(1'b1, 1'b0, 1'b1, 8'h98, "clr_win");
        chk("clr_win_ovf", 32'(bus0.OVERFLOW), 32'h1);
        drv0(1'b0, 1'b0, 1'b1, 8'h00, "clr");
        chk("clr_ovf", 32'(bus0.OVERFLOW), 32'h0);

        // 16 reads; monitor expects 0x01..0x10
        for (int i = 0; i < 16; i++) drv0(1'b0, 1'b1, 1'b0, 8'h00, "rd");
        chk("empty_after_rd", 32'(bus0.EMPTY), 32'h1);
        drv0(1'b0, 1'b1, 1'b0, 8'h00, "udf");
        chk("udf_set",   32'(bus0.UNDERFLOW), 32'h1);
        chk("udf_dout",  32'(bus0.DOUT),      32'h10);

        // Empty + both: write taken, read rejected, DOUT unchanged
        drv0(1'b1, 1'b1, 1'b0, 8'h55, "empty_both");
        chk("eb_count", 32'(bus0.COUNT),     32'd1);
        chk("eb_udf",   32'(bus0.UNDERFLOW), 32'h1);
        chk("eb_dout",  32'(bus0.DOUT),      32'h10);
        drv0(1'b0, 1'b0, 1'b1, 8'h00, "clr2");

        // Bring to COUNT=5, then 40 cycles of simultaneous read/write across wrap
        for (int i = 0; i < 4; i++) drv0(1'b1, 1'b0, 1'b0, 8'(8'h56 + i), "fill5");
        chk("count5", 32'(bus0.COUNT), 32'd5);
        for (int i = 0; i < 40; i++) drv0(1'b1, 1'b1, 1'b0, 8'(8'h60 + i), "both");
        chk("both_count", 32'(bus0.COUNT), 32'd5);

        // Fill, then full + both: read taken, write rejected
        for (int i = 0; i < 11; i++) drv0(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i), "fill16");
        chk("fill16_full", 32'(bus0.FULL), 32'h1);
        drv0(1'b1, 1'b1, 1'b0, 8'hEE, "full_both");
        chk("fb_count", 32'(bus0.COUNT),    32'd15);
        chk("fb_ovf",   32'(bus0.OVERFLOW), 32'h1);

        // Drain to COUNT=9, then reset asynchronously mid-cycle
        for (int i = 0; i < 6; i++) drv0(1'b0, 1'b1, 1'b0, 8'h00, "drain");
        chk("count9", 32'(bus0.COUNT), 32'd9);
        #2;
        RST_N = 1'b0;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_status0("async_rst");
        chk("async_rst_dout", 32'(bus0.DOUT), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;

        // First access after reset is honoured
        drv0(1'b1, 1'b0, 1'b0, 8'hC3, "post_rst_wr");
        chk("post_rst_count", 32'(bus0.COUNT), 32'd1);
        drv0(1'b0, 1'b1, 1'b0, 8'h00, "post_rst_rd");
        step();

        // FWFT instance
        chk("fwft_rst_dout", 32'(bus1.DOUT), 32'h0);
        bus1.WR_EN = 1'b1; bus1.DIN = 8'hA5;
        step(); idle_inputs();
        chk("fwft_wr_dout",  32'(bus1.DOUT),  32'hA5);
        chk("fwft_wr_empty", 32'(bus1.EMPTY), 32'h0);
        step();
        chk("fwft_hold_dout", 32'(bus1.DOUT), 32'hA5);
        bus1.WR_EN = 1'b1; bus1.DIN = 8'h3C;
        step(); idle_inputs();
        chk("fwft_wr2_dout",  32'(bus1.DOUT),  32'hA5);
        chk("fwft_wr2_count", 32'(bus1.COUNT), 32'd2);
        bus1.RD_EN = 1'b1;
        step(); idle_inputs();
        chk("fwft_rd1_dout", 32'(bus1.DOUT), 32'h3C);
        bus1.RD_EN = 1'b1;
        step(); idle_inputs();
        chk("fwft_rd2_dout",  32'(bus1.DOUT),  32'h0);
        chk("fwft_rd2_empty", 32'(bus1.EMPTY), 32'h1);
        bus1.RD_EN = 1'b1;
        step(); idle_inputs();
        chk("fwft_udf",      32'(bus1.UNDERFLOW), 32'h1);
        chk("fwft_udf_dout", 32'(bus1.DOUT),      32'h0);

        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
